stream_to_mem_writer: RTL and testbench



---
 rtl/stream_to_mem_writer_if.sv | 60 ++++++
 rtl/stream_to_mem_writer.sv | 236 +++++++++++++++++++++++
 tb/tb_stream_to_mem_writer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_to_mem_writer_if.sv
// Handshake bundle between the 64-bit capture stream, the writer and the
// 512-bit AXI4 write channels of the memory block.
interface stream_to_mem_writer_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  // Inbound AXI-Stream
  logic [63:0]           stream_in_data;
  logic [7:0]            stream_in_keep;
  logic                  stream_in_last;
  logic                  stream_in_valid;
  logic                  stream_in_ready;

  // AXI4 write address channel
  logic [ADDR_WIDTH-1:0] S_AXI_MEM_0_awaddr;
  logic [7:0]            S_AXI_MEM_0_awlen;
  logic [2:0]            S_AXI_MEM_0_awsize;
  logic [1:0]            S_AXI_MEM_0_awburst;
  logic                  S_AXI_MEM_0_awvalid;
  logic                  S_AXI_MEM_0_awready;

  // AXI4 write data channel
  logic [511:0]          S_AXI_MEM_0_wdata;
  logic [63:0]           S_AXI_MEM_0_wstrb;
  logic                  S_AXI_MEM_0_wlast;
  logic                  S_AXI_MEM_0_wvalid;
  logic                  S_AXI_MEM_0_wready;

  // AXI4 write response channel
  logic [1:0]            S_AXI_MEM_0_bresp;
  logic                  S_AXI_MEM_0_bvalid;
  logic                  S_AXI_MEM_0_bready;

  // Writer view: consumes the stream, masters the memory write channels
  modport master (
    input  stream_in_data, stream_in_keep, stream_in_last, stream_in_valid,
    output stream_in_ready,
    output S_AXI_MEM_0_awaddr, S_AXI_MEM_0_awlen, S_AXI_MEM_0_awsize,
           S_AXI_MEM_0_awburst, S_AXI_MEM_0_awvalid,
    input  S_AXI_MEM_0_awready,
    output S_AXI_MEM_0_wdata, S_AXI_MEM_0_wstrb, S_AXI_MEM_0_wlast,
           S_AXI_MEM_0_wvalid,
    input  S_AXI_MEM_0_wready,
    input  S_AXI_MEM_0_bresp, S_AXI_MEM_0_bvalid,
    output S_AXI_MEM_0_bready
  );

  // Environment view: stream source plus memory slave
  modport slave (
    output stream_in_data, stream_in_keep, stream_in_last, stream_in_valid,
    input  stream_in_ready,
    input  S_AXI_MEM_0_awaddr, S_AXI_MEM_0_awlen, S_AXI_MEM_0_awsize,
           S_AXI_MEM_0_awburst, S_AXI_MEM_0_awvalid,
    output S_AXI_MEM_0_awready,
    input  S_AXI_MEM_0_wdata, S_AXI_MEM_0_wstrb, S_AXI_MEM_0_wlast,
           S_AXI_MEM_0_wvalid,
    output S_AXI_MEM_0_wready,
    output S_AXI_MEM_0_bresp, S_AXI_MEM_0_bvalid,
    input  S_AXI_MEM_0_bready
  );
endinterface

// File: rtl/stream_to_mem_writer.sv
// Packs eight 64-bit stream beats into 512-bit words, buffers them in a word
// FIFO and writes them to memory as INCR bursts at consecutive addresses.
// Bursts never cross a 4 KB page; one burst is outstanding at a time.
module stream_to_mem_writer #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  stream_to_mem_writer_if.master  bus,
  output logic [31:0]             words_written,
  output logic [31:0]             pkt_count,
  output logic                    wr_error
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = 1 + 64 + 512;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- packer
  logic [2:0]   lane_q;
  logic [511:0] part_data_q;
  logic [63:0]  part_strb_q;
  logic [511:0] merged_data;
  logic [63:0]  merged_strb;
  logic         accept;
  logic         push;
  logic         push_tag;

  // ------------------------------------------------------------------ FIFO
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fifo_count_q;
  logic [CNT_W-1:0]   tag_count_q;
  logic               fifo_full;
  logic               pop;
  logic               pop_tag;
  logic [ENTRY_W-1:0] head;

  // ------------------------------------------------------ burst bookkeeping
  logic [ADDR_WIDTH-1:0] addr_next_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [7:0]            beat_q;
  logic [7:0]            tags_q;
  logic [6:0]            page_room;
  logic [15:0]           limit16;
  logic [15:0]           count16;
  logic [15:0]           burst_n16;
  logic [8:0]            burst_words;
  logic                  launch;
  logic                  last_beat;
  logic                  aw_valid, w_valid, b_ready;

  // Ready depends only on registered FIFO occupancy, never on memory inputs
  assign fifo_full           = (fifo_count_q == CNT_W'(FIFO_DEPTH));
  assign bus.stream_in_ready = ~fifo_full;
  assign accept              = bus.stream_in_valid & ~fifo_full;
  assign push                = accept & ((lane_q == 3'd7) | bus.stream_in_last);
  assign push_tag            = push & bus.stream_in_last;

  // Merge the accepted beat into the partial word at the current lane
  always_comb begin
    merged_data = part_data_q;
    merged_strb = part_strb_q;
    merged_data[{lane_q, 6'b0} +: 64] = bus.stream_in_data;
    merged_strb[{lane_q, 3'b0} +: 8]  = bus.stream_in_keep;
  end

  // Lane counter and partial word; cleared whenever a word is pushed
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q      <= '0;
      part_data_q <= '0;
      part_strb_q <= '0;
    end else if (accept) begin
      if (push) begin
        lane_q      <= '0;
        part_data_q <= '0;
        part_strb_q <= '0;
      end else begin
        lane_q      <= lane_q + 3'd1;
        part_data_q <= merged_data;
        part_strb_q <= merged_strb;
      end
    end
  end

  // Word storage; contents need no reset because occupancy gates all reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {push_tag, merged_strb, merged_data};
    end
  end

  assign head    = fifo_mem[rd_ptr_q];
  assign pop     = w_valid & bus.S_AXI_MEM_0_wready;
  assign pop_tag = pop & head[ENTRY_W-1];

  // FIFO pointers, occupancy and count of end-tagged words held
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      tag_count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
      unique case ({push_tag, pop_tag})
        2'b10:   tag_count_q <= tag_count_q + CNT_W'(1);
        2'b01:   tag_count_q <= tag_count_q - CNT_W'(1);
        default: tag_count_q <= tag_count_q;
      endcase
    end
  end

  // Burst limit: words left in the current 4 KB page, capped at MAX_BURST.
  // addr_next is always 64-byte aligned, so only bits [11:6] matter.
  always_comb begin
    page_room = 7'd64 - {1'b0, addr_next_q[11:6]};
    limit16   = (16'(page_room) < 16'(MAX_BURST)) ? 16'(page_room)
                                                  : 16'(MAX_BURST);
    count16   = 16'(fifo_count_q);
    burst_n16 = (count16 < limit16) ? count16 : limit16;
    launch    = (fifo_count_q != '0) &&
                ((count16 >= limit16) || (tag_count_q != '0));
  end

  assign burst_words = {1'b0, awlen_q} + 9'd1;
  assign last_beat   = (beat_q == awlen_q);

  // Burst FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Burst FSM next-state and channel handshake outputs
  always_comb begin
    state_d  = state_q;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = AW;
      end
      AW: begin
        aw_valid = 1'b1;
        if (bus.S_AXI_MEM_0_awready) state_d = W;
      end
      W: begin
        w_valid = 1'b1;
        if (bus.S_AXI_MEM_0_wready && last_beat) state_d = B;
      end
      B: begin
        b_ready = 1'b1;
        if (bus.S_AXI_MEM_0_bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst address/length latching, beat tracking and completion statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_next_q   <= '0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      beat_q        <= '0;
      tags_q        <= '0;
      words_written <= '0;
      pkt_count     <= '0;
      wr_error      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            awaddr_q <= addr_next_q;
            awlen_q  <= 8'(burst_n16 - 16'd1);
            beat_q   <= '0;
            tags_q   <= '0;
          end
        end
        AW: begin
          if (bus.S_AXI_MEM_0_awready) begin
            addr_next_q <= addr_next_q + ADDR_WIDTH'({burst_words, 6'b0});
          end
        end
        W: begin
          if (bus.S_AXI_MEM_0_wready) begin
            beat_q <= beat_q + 8'd1;
            tags_q <= tags_q + {7'b0, head[ENTRY_W-1]};
          end
        end
        B: begin
          if (bus.S_AXI_MEM_0_bvalid) begin
            words_written <= words_written + {23'b0, burst_words};
            pkt_count     <= pkt_count + {24'b0, tags_q};
            if (bus.S_AXI_MEM_0_bresp != 2'b00) wr_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.S_AXI_MEM_0_awaddr  = awaddr_q;
  assign bus.S_AXI_MEM_0_awlen   = awlen_q;
  assign bus.S_AXI_MEM_0_awsize  = 3'b110;
  assign bus.S_AXI_MEM_0_awburst = 2'b01;
  assign bus.S_AXI_MEM_0_awvalid = aw_valid;
  // Head word is only driven during the data phase so wdata/wstrb idle at 0
  assign bus.S_AXI_MEM_0_wdata   = w_valid ? head[511:0]   : '0;
  assign bus.S_AXI_MEM_0_wstrb   = w_valid ? head[575:512] : '0;
  assign bus.S_AXI_MEM_0_wlast   = w_valid & last_beat;
  assign bus.S_AXI_MEM_0_wvalid  = w_valid;
  assign bus.S_AXI_MEM_0_bready  = b_ready;

endmodule

// File: tb/tb_stream_to_mem_writer.sv
// Bench for stream_to_mem_writer: table of packet scenarios plus hand-written
// sequences for page crossing, back-pressure, error response and wrap.
module tb_stream_to_mem_writer;

  localparam int unsigned AWD = 15;
  localparam int unsigned MB  = 16;
  localparam int unsigned FD  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_to_mem_writer_if #(.ADDR_WIDTH(AWD)) bus ();
  logic [31:0] words_written;
  logic [31:0] pkt_count;
  logic        wr_error;

  stream_to_mem_writer #(
    .ADDR_WIDTH(AWD),
    .MAX_BURST (MB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .words_written(words_written),
    .pkt_count    (pkt_count),
    .wr_error     (wr_error)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Scoreboard of expected memory words, in stream order
  typedef struct {
    logic [511:0] data;
    logic [63:0]  strb;
    logic         tag;
  } word_t;
  word_t exp_q[$];

  typedef struct {
    logic [AWD-1:0] addr;
    logic [7:0]     len;
  } aw_t;
  aw_t aw_log[$];

  // Packing model state
  logic [511:0] m_data;
  logic [63:0]  m_strb;
  int unsigned  m_lane;

  // Memory model state
  bit             aw_hold = 0;
  logic [1:0]     bresp_cfg = 2'b00;
  bit             in_burst = 0, pending_b = 0, cnt_chk = 0, aw_wait = 0;
  logic [AWD-1:0] exp_addr = '0;
  logic [AWD-1:0] prev_awaddr;
  logic [7:0]     prev_awlen;
  int unsigned    cur_len = 0, beat = 0, burst_tags = 0;
  int unsigned    exp_ww = 0, exp_pc = 0;
  bit             exp_err = 0;
  logic [63:0]    last_strb = '0;
  bit             ready_low_seen = 0;
  int unsigned    accepted = 0;

  // Memory slave: drives inputs each negedge, then judges the handshakes that
  // will complete on the following posedge
  initial begin
    bus.S_AXI_MEM_0_awready = 1'b0;
    bus.S_AXI_MEM_0_wready  = 1'b0;
    bus.S_AXI_MEM_0_bvalid  = 1'b0;
    bus.S_AXI_MEM_0_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_burst = 0; pending_b = 0; cnt_chk = 0; aw_wait = 0;
        bus.S_AXI_MEM_0_awready = 1'b0;
        bus.S_AXI_MEM_0_wready  = 1'b0;
        bus.S_AXI_MEM_0_bvalid  = 1'b0;
        continue;
      end
      if (cnt_chk) begin
        check("words_written", words_written, exp_ww);
        check("pkt_count", pkt_count, exp_pc);
        check("wr_error", wr_error, exp_err);
        cnt_chk = 0;
      end
      bus.S_AXI_MEM_0_awready = !aw_hold;
      bus.S_AXI_MEM_0_wready  = ($urandom_range(0, 3) != 0);
      bus.S_AXI_MEM_0_bvalid  = pending_b;
      bus.S_AXI_MEM_0_bresp   = pending_b ? bresp_cfg : 2'b00;
      if (!bus.stream_in_ready) ready_low_seen = 1;

      if (bus.S_AXI_MEM_0_awvalid) begin
        check("aw_overlap", in_burst, 1'b0);
        if (aw_wait) begin
          check("aw_hold_addr", bus.S_AXI_MEM_0_awaddr, prev_awaddr);
          check("aw_hold_len", bus.S_AXI_MEM_0_awlen, prev_awlen);
        end
        if (bus.S_AXI_MEM_0_awready) begin
          int a;
          int n;
          aw_t r;
          a = int'(bus.S_AXI_MEM_0_awaddr[11:0]);
          n = int'(bus.S_AXI_MEM_0_awlen) + 1;
          check("awaddr", bus.S_AXI_MEM_0_awaddr, exp_addr);
          check("awsize", bus.S_AXI_MEM_0_awsize, 3'b110);
          check("awburst", bus.S_AXI_MEM_0_awburst, 2'b01);
          check("aw_len_max", (n <= int'(MB)), 1'b1);
          check("aw_4k_cross", (a + n * 64 <= 4096), 1'b1);
          r.addr = bus.S_AXI_MEM_0_awaddr;
          r.len  = bus.S_AXI_MEM_0_awlen;
          aw_log.push_back(r);
          exp_addr   = exp_addr + AWD'(n * 64);
          cur_len    = n - 1;
          beat       = 0;
          burst_tags = 0;
          in_burst   = 1;
          aw_wait    = 0;
        end else begin
          aw_wait     = 1;
          prev_awaddr = bus.S_AXI_MEM_0_awaddr;
          prev_awlen  = bus.S_AXI_MEM_0_awlen;
        end
      end

      if (bus.S_AXI_MEM_0_wvalid && bus.S_AXI_MEM_0_wready) begin
        check("w_in_burst", in_burst, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_extra: got beat %0h expected no beat",
                   bus.S_AXI_MEM_0_wstrb);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          check("wdata", bus.S_AXI_MEM_0_wdata, w.data);
          check("wstrb", bus.S_AXI_MEM_0_wstrb, w.strb);
          check("wlast", bus.S_AXI_MEM_0_wlast, (beat == cur_len));
          burst_tags += w.tag ? 1 : 0;
          last_strb = bus.S_AXI_MEM_0_wstrb;
          beat++;
          if (beat > cur_len) pending_b = 1;
        end
      end

      if (bus.S_AXI_MEM_0_bvalid && bus.S_AXI_MEM_0_bready) begin
        exp_ww += cur_len + 1;
        exp_pc += burst_tags;
        if (bus.S_AXI_MEM_0_bresp != 2'b00) exp_err = 1;
        in_burst  = 0;
        pending_b = 0;
        cnt_chk   = 1;
      end
    end
  end

  // Packing model: expected word pushed when the beat is driven and accepted
  task automatic model_accept(input logic [63:0] d, input logic [7:0] k,
                              input logic l);
    word_t w;
    m_data[64*m_lane +: 64] = d;
    m_strb[8*m_lane +: 8]   = k;
    if (m_lane == 7 || l) begin
      w.data = m_data;
      w.strb = m_strb;
      w.tag  = l;
      exp_q.push_back(w);
      m_data = '0;
      m_strb = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l);
    int unsigned budget;
    budget = 0;
    bus.stream_in_data  = d;
    bus.stream_in_keep  = k;
    bus.stream_in_last  = l;
    bus.stream_in_valid = 1'b1;
    while (!bus.stream_in_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 2000) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: got ready=0 for %0d cycles expected ready", budget);
        finish_run();
      end
    end
    model_accept(d, k, l);
    accepted++;
    @(negedge clk);
    bus.stream_in_valid = 1'b0;
  endtask

  task automatic send_packet(input int beats, input logic [7:0] last_keep);
    for (int i = 0; i < beats; i++) begin
      send_beat({$urandom, $urandom}, (i == beats - 1) ? last_keep : 8'hFF,
                (i == beats - 1));
    end
  endtask

  task automatic wait_idle();
    int unsigned budget;
    budget = 0;
    while (exp_q.size() != 0 || in_burst || pending_b || cnt_chk) begin
      @(negedge clk);
      budget++;
      if (budget > 5000) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d words pending expected 0",
                 exp_q.size());
        finish_run();
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.stream_in_valid = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    aw_log.delete();
    m_data = '0; m_strb = '0; m_lane = 0;
    exp_addr = '0; exp_ww = 0; exp_pc = 0; exp_err = 0;
    repeat (3) @(negedge clk);
    check("rst_awvalid", bus.S_AXI_MEM_0_awvalid, 1'b0);
    check("rst_wvalid", bus.S_AXI_MEM_0_wvalid, 1'b0);
    check("rst_bready", bus.S_AXI_MEM_0_bready, 1'b0);
    check("rst_awaddr", bus.S_AXI_MEM_0_awaddr, '0);
    check("rst_awlen", bus.S_AXI_MEM_0_awlen, '0);
    check("rst_wdata", bus.S_AXI_MEM_0_wdata, '0);
    check("rst_wstrb", bus.S_AXI_MEM_0_wstrb, '0);
    check("rst_wlast", bus.S_AXI_MEM_0_wlast, 1'b0);
    check("rst_words_written", words_written, '0);
    check("rst_pkt_count", pkt_count, '0);
    check("rst_wr_error", wr_error, 1'b0);
    check("rst_awsize", bus.S_AXI_MEM_0_awsize, 3'b110);
    check("rst_awburst", bus.S_AXI_MEM_0_awburst, 2'b01);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.stream_in_ready, 1'b1);
  endtask

  typedef struct {
    bit             rst;
    int             beats;
    logic [7:0]     last_keep;
    logic [AWD-1:0] exp_addr;
    logic [7:0]     exp_len;
    logic [63:0]    exp_last_strb;
    int unsigned    exp_ww;
    int unsigned    exp_pc;
  } vec_t;

  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got no completion expected finish");
    finish_run();
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{1'b1, 16,  8'hFF, 15'h0000, 8'd1,  64'hFFFFFFFFFFFFFFFF, 2,  1};
    vecs[1] = '{1'b0, 3,   8'h0F, 15'h0080, 8'd0,  64'h00000000000FFFFF, 3,  2};
    vecs[2] = '{1'b1, 128, 8'hFF, 15'h0000, 8'd15, 64'hFFFFFFFFFFFFFFFF, 16, 1};
    vecs[3] = '{1'b0, 8,   8'hFF, 15'h0400, 8'd0,  64'hFFFFFFFFFFFFFFFF, 17, 2};

    bus.stream_in_valid = 1'b0;
    bus.stream_in_data  = '0;
    bus.stream_in_keep  = '0;
    bus.stream_in_last  = 1'b0;
    m_data = '0; m_strb = '0; m_lane = 0;
    @(negedge clk);
    do_reset();

    // Table-driven packet scenarios
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].rst) do_reset();
      aw_log.delete();
      send_packet(vecs[i].beats, vecs[i].last_keep);
      wait_idle();
      check($sformatf("vec%0d_bursts", i), (aw_log.size() > 0), 1'b1);
      if (aw_log.size() > 0) begin
        check($sformatf("vec%0d_awaddr", i), aw_log[0].addr, vecs[i].exp_addr);
        check($sformatf("vec%0d_awlen", i), aw_log[0].len, vecs[i].exp_len);
      end
      check($sformatf("vec%0d_last_wstrb", i), last_strb, vecs[i].exp_last_strb);
      check($sformatf("vec%0d_words", i), words_written, vecs[i].exp_ww);
      check($sformatf("vec%0d_pkts", i), pkt_count, vecs[i].exp_pc);
    end

    // 4 KB page boundary: last word of a page goes alone, rest in next page
    do_reset();
    for (int i = 0; i < 63; i++) begin
      send_packet(8, 8'hFF);
      wait_idle();
    end
    aw_log.delete();
    send_packet(32, 8'hFF);
    wait_idle();
    check("page_bursts", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      check("page_b0_addr", aw_log[0].addr, 15'h0FC0);
      check("page_b0_len", aw_log[0].len, 8'd0);
      check("page_b1_addr", aw_log[1].addr, 15'h1000);
      check("page_b1_len", aw_log[1].len, 8'd2);
    end
    check("page_words", words_written, 67);

    // awready stall: FIFO fills, ready drops, nothing lost
    do_reset();
    aw_hold = 1;
    accepted = 0;
    ready_low_seen = 0;
    fork
      send_packet(320, 8'hFF);
      begin
        repeat (300) @(negedge clk);
        check("stall_accepted", accepted, 256);
        check("stall_ready_low_seen", ready_low_seen, 1'b1);
        check("stall_ready", bus.stream_in_ready, 1'b0);
        aw_hold = 0;
      end
    join
    wait_idle();
    check("stall_words", words_written, 40);
    check("stall_pkts", pkt_count, 1);

    // Error response is sticky until reset
    bresp_cfg = 2'b10;
    send_packet(8, 8'hFF);
    wait_idle();
    bresp_cfg = 2'b00;
    check("err_set", wr_error, 1'b1);
    send_packet(8, 8'hFF);
    wait_idle();
    check("err_sticky", wr_error, 1'b1);

    // Address wrap at the top of the space
    do_reset();
    send_packet(511 * 8, 8'hFF);
    wait_idle();
    aw_log.delete();
    send_packet(16, 8'hFF);
    wait_idle();
    check("wrap_bursts", aw_log.size(), 2);
    if (aw_log.size() == 2) begin
      check("wrap_b0_addr", aw_log[0].addr, 15'h7FC0);
      check("wrap_b0_len", aw_log[0].len, 8'd0);
      check("wrap_b1_addr", aw_log[1].addr, 15'h0000);
      check("wrap_b1_len", aw_log[1].len, 8'd0);
    end
    check("wrap_words", words_written, 513);
    check("wrap_pkts", pkt_count, 2);

    finish_run();
  end

endmodule
